// File: rtl/uart_alu_intf.sv
// uart_alu_intf: collects an (A, B, opcode) frame from a UART receiver,
// presents it to a combinational ALU and returns the one-byte result
// through the transmitter start/done handshake. A partial frame that
// stalls longer than TIMEOUT_CYCLES between bytes is dropped so the host
// can resynchronise on the next byte.

module uart_alu_intf #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_frame_err
);

    // A zero timeout disables the check; keep the counter at least one bit
    // wide so the declarations stay legal in that configuration.
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int   CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [NB_DATA-1:0] alu_a_q,     alu_a_d;
    logic [NB_DATA-1:0] alu_b_q,     alu_b_d;
    logic [NB_OP-1:0]   alu_op_q,    alu_op_d;
    logic [NB_DATA-1:0] tx_data_q,   tx_data_d;
    logic               tx_start_q,  tx_start_d;
    logic               busy_q,      busy_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               timeout_hit_s;

    // Inter-byte timeout fires when the idle count reaches its last value.
    always_comb begin
        if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Frame collection FSM: next state, operand capture, timeout and outputs.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                // An arriving byte wins over an expiring timeout.
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else if (timeout_hit_s) begin
                    state_d     = ST_WAIT_A;
                    frame_err_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_B;
                    cnt_d   = TIMEOUT_EN ? (cnt_q + CNT_ONE) : {CNT_W{1'b0}};
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = ST_EXEC;
                end else if (timeout_hit_s) begin
                    state_d     = ST_WAIT_A;
                    frame_err_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_OP;
                    cnt_d   = TIMEOUT_EN ? (cnt_q + CNT_ONE) : {CNT_W{1'b0}};
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for a full cycle; take the result
                // and raise the start request so it lines up with SEND.
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        case (state_d)
            ST_EXEC, ST_SEND, ST_WAIT_TX: busy_d = 1'b1;
            default:                      busy_d = 1'b0;
        endcase
    end

    // State, operand, counter and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_WAIT_A;
            alu_a_q     <= {NB_DATA{1'b0}};
            alu_b_q     <= {NB_DATA{1'b0}};
            alu_op_q    <= {NB_OP{1'b0}};
            tx_data_q   <= {NB_DATA{1'b0}};
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

    uart_alu_intf_chk u_chk (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tx_start (tx_start_q),
        .i_busy     (busy_q)
    );

endmodule

// Protocol properties of the responder's transmit side.
module uart_alu_intf_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_tx_start,
    input logic i_busy
);

    // A transmit request is a single-cycle pulse.
    a_start_single : assert property (@(posedge i_clk) disable iff (!i_reset)
        i_tx_start |=> !i_tx_start);

    // A transmit request is only issued while the block reports busy.
    a_start_busy : assert property (@(posedge i_clk) disable iff (!i_reset)
        i_tx_start |-> i_busy);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: directed scenarios plus randomised frames,
// with a small ALU attached and an arithmetic reference for the result.

module tb_uart_alu_intf;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO      = 100;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic [NB_DATA-1:0] rx_data = 8'h00;
    logic               rx_done = 1'b0;
    logic               tx_done = 1'b0;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic               busy;
    logic               frame_err;

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    logic prev_start = 1'b0;

    uart_alu_intf #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_busy       (busy),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Attached ALU: 0x20 ADD, 0x22 SUB, 0x24 AND, anything else XOR.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    // Expected response byte for a frame, from plain integer arithmetic.
    function automatic int ref_alu(input int a, input int b, input int opbyte);
        int op;
        int r;
        op = opbyte % 64;
        if (op == 32)      r = a + b;
        else if (op == 34) r = a - b + 256;
        else if (op == 36) r = a & b;
        else               r = a ^ b;
        return r % 256;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count transmit requests and frame errors; flag back-to-back starts.
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                check_eq("start_single", 32'(prev_start), 32'd0);
                start_cnt++;
            end
            if (frame_err) err_cnt++;
            prev_start = tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // All tasks begin and end on a falling clock edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check_eq({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check_eq({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check_eq({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input int gap, input bit tx_done_in_send, input bit inject_rx);
        int s0;
        int exp;
        exp = ref_alu(int'(a), int'(b), int'(opb));
        s0  = start_cnt;
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        send_byte(opb);
        // First cycle after the opcode byte: ALU inputs presented, block busy.
        check_eq("alu_a", 32'(alu_a), 32'(a));
        check_eq("alu_b", 32'(alu_b), 32'(b));
        check_eq("alu_op", 32'(alu_op), 32'(int'(opb) % 64));
        check_eq("busy_rise", 32'(busy), 32'd1);
        check_eq("start_early", 32'(tx_start), 32'd0);
        @(negedge clk);
        check_eq("start_pulse", 32'(tx_start), 32'd1);
        check_eq("tx_data", 32'(tx_data), 32'(exp));
        if (tx_done_in_send) tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("start_end", 32'(tx_start), 32'd0);
        check_eq("busy_wait_tx", 32'(busy), 32'd1);
        check_eq("tx_data_hold", 32'(tx_data), 32'(exp));
        if (inject_rx) begin
            send_byte(8'h77);
            check_eq("ignored_rx_a", 32'(alu_a), 32'(a));
            check_eq("ignored_rx_busy", 32'(busy), 32'd1);
        end
        idle($urandom_range(0, 5));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("start_count", 32'(start_cnt - s0), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int s0;
        int err_at;
        logic [7:0] ops [6];
        ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
        ops[3] = 8'hE0; ops[4] = 8'hE2; ops[5] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD and SUB with opcode upper bits discarded.
        run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b0);
        run_frame(8'h03, 8'h05, 8'hE2, 0, 1'b0, 1'b0);

        // Partial frame dropped after the inter-byte timeout.
        e0 = err_cnt;
        send_byte(8'h11);
        err_at = 0;
        for (int i = 1; i <= 130; i++) begin
            if (frame_err && err_at == 0) err_at = i;
            @(negedge clk);
        end
        check_eq("timeout_err_cycle", 32'(err_at), 32'd101);
        check_eq("timeout_err_count", 32'(err_cnt - e0), 32'd1);
        check_eq("timeout_busy", 32'(busy), 32'd0);
        run_frame(8'h02, 8'h02, 8'h20, 0, 1'b0, 1'b0);

        // Bytes landing exactly on the expiry cycle are accepted.
        e0 = err_cnt;
        run_frame(8'h40, 8'h30, 8'h22, TO - 1, 1'b0, 1'b0);
        check_eq("expiry_no_err", 32'(err_cnt - e0), 32'd0);

        // Receive activity during WAIT_TX is ignored; tx_done during SEND too.
        run_frame(8'h55, 8'h12, 8'h22, 2, 1'b1, 1'b1);
        run_frame(8'h01, 8'h01, 8'h20, 0, 1'b0, 1'b0);

        // Reset while waiting for the opcode.
        s0 = start_cnt;
        send_byte(8'h09);
        send_byte(8'h07);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait_op");
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check_eq("rst_wait_op_no_start", 32'(start_cnt - s0), 32'd0);

        // Reset while waiting for the transmitter.
        s0 = start_cnt;
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h20);
        idle(4);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait_tx");
        @(negedge clk);
        rst_n = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        idle(10);
        check_eq("rst_wait_tx_no_start", 32'(start_cnt - s0), 32'd1);
        check_eq("rst_wait_tx_busy", 32'(busy), 32'd0);
        run_frame(8'h21, 8'h0C, 8'h24, 1, 1'b0, 1'b0);

        // Randomised frames within the timeout window.
        e0 = err_cnt;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [7:0] ro;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = ($urandom_range(0, 5) == 5) ? 8'($urandom) : ops[$urandom_range(0, 4)];
            run_frame(ra, rb, ro, $urandom_range(0, TO - 1),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_eq("random_no_err", 32'(err_cnt - e0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_intf.md
# uart_alu_intf

UART-side command responder between `uart_rx`/`uart_tx` and a combinational ALU, replacing the raw RX→TX echo path. It collects a three-byte frame from the receiver in the order operand A, operand B, opcode, and drives the ALU inputs from that frame. It then returns the one-byte ALU result through the transmitter start/done handshake. An inter-byte timeout drops partial frames so the host can resynchronise.

## Interface
- `NB_DATA`, 8: UART byte width and ALU operand/result width.
- `NB_OP`, 6: opcode width; taken from the low bits of the opcode byte (NB_OP ≤ NB_DATA).
- `TIMEOUT_CYCLES`, 500000: idle clock cycles allowed between bytes of one frame (10 ms at 50 MHz); 0 disables the timeout.

- `i_clk` in 1: system clock (50 MHz domain).
- `i_reset` in 1: asynchronous, active-low reset.
- `i_rx_data` in NB_DATA: byte from `uart_rx`; valid only in the cycle `i_rx_done`=1.
- `i_rx_done` in 1: one-cycle byte-received pulse.
- `i_tx_done` in 1: one-cycle pulse from `uart_tx` when the stop bit completes.
- `o_tx_data` out NB_DATA: byte to `uart_tx`; registered, stable from SEND through WAIT_TX.
- `o_tx_start` out 1: one-cycle transmit request.
- `o_alu_a` out NB_DATA: registered operand A.
- `o_alu_b` out NB_DATA: registered operand B.
- `o_alu_op` out NB_OP: registered opcode.
- `i_alu_result` in NB_DATA: combinational ALU result of `o_alu_a`/`o_alu_b`/`o_alu_op`.
- `o_busy` out 1: high in EXEC, SEND and WAIT_TX.
- `o_frame_err` out 1: one-cycle pulse when a partial frame is discarded by timeout.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state is WAIT_A.
- WAIT_A: when `i_rx_done`=1, capture the byte into `o_alu_a` and go to WAIT_B.
- WAIT_B: when `i_rx_done`=1, capture the byte into `o_alu_b` and go to WAIT_OP.
- WAIT_OP: when `i_rx_done`=1, capture `i_rx_data[NB_OP-1:0]` into `o_alu_op` and go to EXEC. Upper opcode bits are discarded.
- EXEC: one cycle for the ALU to settle. Latch `i_alu_result` into `o_tx_data`, then go to SEND.
- SEND: `o_tx_start`=1 for this cycle only, then go to WAIT_TX.
- WAIT_TX: wait for `i_tx_done`=1, then go to WAIT_A.
- `i_rx_done` in EXEC, SEND or WAIT_TX is ignored. The byte is lost and the operand registers are unchanged.
- `i_tx_done` outside WAIT_TX (including the SEND cycle) is ignored.
- Operand registers hold their values until overwritten by the next frame.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on every accepted byte and in every state other than WAIT_B/WAIT_OP.
  - Increments each cycle in WAIT_B/WAIT_OP while `i_rx_done`=0.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: next state is WAIT_A and `o_frame_err` pulses for one cycle, registered (high in the first WAIT_A cycle).
  - `i_rx_done` in the expiry cycle wins: the byte is accepted and no error is flagged.
  - No timeout applies in WAIT_A or WAIT_TX.
- Reset values: all outputs 0, state WAIT_A, counter 0.
- Reset assertion mid-frame or mid-transmit returns the block to WAIT_A immediately. No `o_tx_start` is issued afterward for the aborted frame.

## Timing
- Opcode `i_rx_done` in cycle n:
  - `o_alu_op` valid and state EXEC in n+1.
  - `o_tx_data` = result, `o_tx_start`=1 in n+2.
  - WAIT_TX from n+3.
- Operand outputs update on the clock edge that ends the `i_rx_done` cycle.
- `o_busy` rises in n+1 and falls in the cycle after `i_tx_done` (first WAIT_A cycle).
- Back-to-back frames: a byte accepted in the first WAIT_A cycle after `i_tx_done` is valid.
- `o_tx_start` is never high in two consecutive cycles.

## Test plan
- Bench ALU model: 0x20 = ADD, 0x22 = SUB. Send 0x05, 0x03, 0x20 → `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20, `o_tx_data`=0x08, `o_tx_start` single pulse at n+2. Pulse `i_tx_done` → WAIT_A, `o_busy`=0.
- Send 0x03, 0x05, 0xE2 with NB_OP=6 → `o_alu_op`=0x22, result byte 0xFE.
- TIMEOUT_CYCLES=100: send 0x11 then nothing → `o_frame_err` pulse exactly once after 100 cycles. Then 0x02, 0x02, 0x20 → `o_tx_data`=0x04.
- TIMEOUT_CYCLES=100: second byte's `i_rx_done` lands on the expiry cycle → byte accepted, no `o_frame_err`.
- During WAIT_TX inject `i_rx_done` with 0x77 → ignored, `o_alu_a` unchanged. After `i_tx_done`, a full frame 0x01, 0x01, 0x20 returns 0x02.
- Assert `i_reset`=0 in WAIT_OP and again in WAIT_TX → all outputs 0 within the reset cycle, no `o_tx_start` after release.
